// File: rtl/anc_sample_scheduler.sv
// anc_sample_scheduler: queues (e, x, a) sample triplets in a small FIFO and
// issues one triplet per ANC FIR/LMS pass, with an annealed LMS step size.
//
// Handshakes:
//   source side: a sample moves on an edge where s_valid && s_ready. s_ready is
//                !full, derived from the occupancy before the edge. A sample
//                offered while full is dropped and counted; a pop on the same
//                edge does not rescue it.
//   ANC side:    an issue happens on an edge where the FSM is idle, the FIFO is
//                non-empty and anc_ready is high. anc_in_valid is then high for
//                exactly one cycle. The pass retires on anc_out_valid, which is
//                only observed while waiting.
module anc_sample_scheduler #(
  parameter int DEPTH       = 4,
  parameter int AW          = 2,
  parameter int DECAY_SHIFT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_e,
  input  logic [15:0] s_x,
  input  logic [15:0] s_a,
  input  logic [15:0] cfg_u_init,
  input  logic [15:0] cfg_u_min,
  input  logic        cfg_anneal_en,
  input  logic        cfg_load,
  output logic        anc_in_valid,
  input  logic        anc_ready,
  output logic [15:0] anc_e,
  output logic [15:0] anc_x,
  output logic [15:0] anc_a,
  output logic [15:0] anc_u,
  input  logic        anc_out_valid,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  ovf_count,
  output logic [15:0] issued_count,
  output logic        dbg_state_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [47:0]            mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q, count_d;

  // Sequencer and operand registers
  state_t                 state_q;
  logic                   anc_in_valid_q;
  logic [15:0]            anc_e_q, anc_x_q, anc_a_q, anc_u_q;

  // Step size and statistics
  logic [15:0]            u_cur_q, u_cur_d;
  logic [DECAY_SHIFT-1:0] anneal_cnt_q, anneal_cnt_d;
  logic                   overrun_q;
  logic [7:0]             ovf_count_q;
  logic [15:0]            issued_count_q;

  logic                   fifo_full, fifo_empty;
  logic                   push, drop, issue;
  logic                   anneal_wrap;
  logic signed [15:0]     u_half_s;
  logic [15:0]            u_annealed;
  logic [47:0]            head;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign s_ready    = !fifo_full;
  assign push       = s_valid && !fifo_full;
  assign drop       = s_valid && fifo_full;
  assign issue      = (state_q == ST_IDLE) && !fifo_empty && anc_ready;
  assign head       = mem_q[rd_ptr_q];

  // Anneal fires on the issue edge where the counter wraps back to zero.
  assign anneal_wrap = issue && (anneal_cnt_q == '1);
  assign u_half_s    = $signed(u_cur_q) >>> 1;
  assign u_annealed  = (u_half_s < $signed(cfg_u_min)) ? cfg_u_min : u_half_s;

  // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Step size and anneal counter: cfg_load overrides any anneal on the same edge.
  always_comb begin
    u_cur_d      = u_cur_q;
    anneal_cnt_d = anneal_cnt_q;
    if (issue) begin
      anneal_cnt_d = anneal_cnt_q + 1'b1;
    end
    if (anneal_wrap && cfg_anneal_en) begin
      u_cur_d = u_annealed;
    end
    if (cfg_load) begin
      u_cur_d      = cfg_u_init;
      anneal_cnt_d = '0;
    end
  end

  // FIFO data array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_e, s_x, s_a};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Issue sequencer with registered strobe and operands; anc_u takes the
  // step size from before any anneal or load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      anc_in_valid_q <= 1'b0;
      anc_e_q        <= '0;
      anc_x_q        <= '0;
      anc_a_q        <= '0;
      anc_u_q        <= '0;
    end else begin
      anc_in_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            anc_in_valid_q <= 1'b1;
            anc_e_q        <= head[47:32];
            anc_x_q        <= head[31:16];
            anc_a_q        <= head[15:0];
            anc_u_q        <= u_cur_q;
            state_q        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (anc_out_valid) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Step size, anneal counter, and sample statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cur_q        <= '0;
      anneal_cnt_q   <= '0;
      overrun_q      <= 1'b0;
      ovf_count_q    <= '0;
      issued_count_q <= '0;
    end else begin
      u_cur_q      <= u_cur_d;
      anneal_cnt_q <= anneal_cnt_d;
      if (drop) begin
        overrun_q <= 1'b1;
        if (ovf_count_q != 8'hFF) ovf_count_q <= ovf_count_q + 1'b1;
      end
      if (issue) issued_count_q <= issued_count_q + 1'b1;
    end
  end

  assign anc_in_valid = anc_in_valid_q;
  assign anc_e        = anc_e_q;
  assign anc_x        = anc_x_q;
  assign anc_a        = anc_a_q;
  assign anc_u        = anc_u_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign overrun      = overrun_q;
  assign ovf_count    = ovf_count_q;
  assign issued_count = issued_count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/anc_sample_scheduler.md
# anc_sample_scheduler

Front-end sequencer for the ANC core. Accepts (e, x, a) sample triplets from the acquisition side into a small FIFO and issues exactly one triplet per FIR/LMS pass to the ANC top level. Hands off on `controller_ready` and retires each pass on `out_valid`. Also generates the LMS step size `u` on an annealing schedule and reports overruns.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- AW, 2: log2(DEPTH)
- DECAY_SHIFT, 10: issued samples per anneal step = 2^DECAY_SHIFT
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  source sample valid
- s_ready  out  1  FIFO can accept; = !full, combinational from occupancy
- s_e, s_x, s_a  in  16 each  signed error, reference, desired samples
- cfg_u_init  in  16  signed initial step size, sampled on cfg_load
- cfg_u_min  in  16  signed anneal floor, read live
- cfg_anneal_en  in  1  enable step-size decay
- cfg_load  in  1  one-cycle pulse: u_cur ← cfg_u_init, anneal counter ← 0
- anc_in_valid  out  1  registered one-cycle issue strobe to the ANC core
- anc_ready  in  1  ANC controller ready (`controller_ready`)
- anc_e, anc_x, anc_a, anc_u  out  16 each  registered signed operands, held until next issue
- anc_out_valid  in  1  ANC pass complete (`out_valid`)
- busy  out  1  state≠IDLE or FIFO non-empty
- overrun  out  1  sticky; set when a sample is dropped; cleared only by reset
- ovf_count  out  8  dropped samples, saturates at 255
- issued_count  out  16  issued samples, wraps modulo 2^16

## Operation
- FIFO: DEPTH×48-bit entries {e,x,a}. Read/write pointers are AW bits and wrap. Occupancy counter is AW+1 bits.
- Push occurs when s_valid && s_ready.
- s_valid && !s_ready drops the sample: overrun←1, ovf_count+1 (saturating).
- A pop on the same edge does not rescue a sample offered while full; s_ready is evaluated before the edge.
- Push and pop on the same edge leave occupancy unchanged. Both pointers advance.
- FSM states:
  - IDLE: if FIFO non-empty && anc_ready → at the edge, load anc_e/x/a from the head and anc_u←u_cur, pulse anc_in_valid, pop, issued_count+1, anneal counter+1 → WAIT. Otherwise stay in IDLE.
  - WAIT: anc_in_valid=0. On anc_out_valid → IDLE. No new issue while in WAIT.
- anc_out_valid in IDLE is ignored.
- Step size u_cur (16-bit signed):
  - Annealing applies when the anneal counter (DECAY_SHIFT bits) wraps to 0 on an issue edge and cfg_anneal_en=1.
  - On that edge: u_cur ← max(u_cur >>> 1, cfg_u_min), as a signed compare.
  - Anneal is applied after the current sample's anc_u is latched. The sample issued at the wrap uses the old u.
- cfg_load has priority over an anneal on the same edge. It affects only samples issued on later edges.
- With cfg_anneal_en=0 the counter still runs, but u_cur is held.
- Async reset, including mid-pass:
  - FIFO emptied, pointers 0, state IDLE.
  - u_cur=0, anneal counter 0.
  - All outputs 0, except s_ready=1.
  - A pending ANC pass is abandoned. The ANC core is reset by the same rst_n.

## Timing
- Reset values: s_ready=1, anc_in_valid=0, anc_e/x/a/u=0, busy=0, overrun=0, ovf_count=0, issued_count=0.
- Latency, empty FIFO in IDLE with anc_ready=1:
  - Sample accepted at edge N.
  - anc_in_valid is high for the cycle after edge N+1, with operands valid in the same cycle.
- anc_in_valid is never high for two consecutive cycles.
- Minimum gap between issues: anc_out_valid edge + 1 edge.
- Throughput: one sample per ANC pass. The source may burst DEPTH samples without loss while a pass is in flight.

## Test plan
- Single sample: cfg_load with u_init=0x0100; push e=0x0010, x=0x0020, a=0x0030 with anc_ready=1 → anc_in_valid exactly 2 edges after accept; anc_e/x/a/u = 0x0010/0x0020/0x0030/0x0100; state WAIT until anc_out_valid; issued_count=1.
- Burst/overrun, DEPTH=4: push 6 samples back-to-back while in WAIT → first 4 accepted, s_ready=0 thereafter, 2 dropped, ovf_count=2, overrun=1; after 4 anc_out_valid pulses, 4 issues occur in FIFO order.
- Anneal, DECAY_SHIFT=2: u_init=0x0100, u_min=0x0030, anneal_en=1; issue 12 samples → anc_u sequence 0x100 ×4, 0x080 ×4, 0x040 ×4; next step floors at 0x0030.
- Simultaneous edge: cfg_load (u_init=0x0200) on the same edge as an anneal wrap → u_cur=0x0200, counter 0; the sample issued on that edge carries the old u.
- Spurious/held ready: anc_out_valid pulsed in IDLE with empty FIFO → no issue, no state change; anc_ready=0 with a non-empty FIFO → no issue until anc_ready=1.
- Reset mid-operation: assert rst_n low in WAIT with 3 entries queued → all outputs at reset values immediately (asynchronously); after release, busy=0 and no issue without new pushes.
